// File: rtl/counter_32_if.sv
// Control/status bundle for counter_32: the controller drives the master side,
// the counter implements the slave side.
interface counter_32_if;
   logic        start;
   logic        stop;
   logic        en;
   logic        up;
   logic [31:0] step;
   logic        load;
   logic [31:0] load_val;
   logic [31:0] limit;
   logic        one_shot;
   logic [31:0] count;
   logic        running;
   logic        done;
   logic        tc;
   logic        wrap;

   modport master (
      output start, stop, en, up, step, load, load_val, limit, one_shot,
      input  count, running, done, tc, wrap
   );

   modport slave (
      input  start, stop, en, up, step, load, load_val, limit, one_shot,
      output count, running, done, tc, wrap
   );
endinterface

// File: rtl/counter_32.sv
// Programmable up/down counter with free-run and one-shot modes; the count
// register is advanced through a single ripple adder with carry-based wrap detect.
module adder_32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] s,
   output logic        cout
);
   logic [32:0] c;

   assign c[0] = cin;
   for (genvar i = 0; i < 32; i++) begin : g_bit
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign cout = c[32];
endmodule

module counter_32 #(
   parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   counter_32_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e      state_q, state_d;
   logic [31:0] count_q, count_d;
   logic        os_q, os_d;
   logic        tc_q, tc_d;
   logic        wrap_q, wrap_d;

   logic [31:0] b_op;
   logic [31:0] sum;
   logic        cout;

   // Subtract as count + ~step + 1, so carry-out is the inverse of borrow.
   assign b_op = bus.up ? bus.step : ~bus.step;

   adder_32 u_add (
      .a    (count_q),
      .b    (b_op),
      .cin  (~bus.up),
      .s    (sum),
      .cout (cout)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      os_d    = os_q;
      tc_d    = 1'b0;
      wrap_d  = 1'b0;
      if (bus.stop) begin
         state_d = IDLE;
      end else if (bus.start && state_q != RUN) begin
         count_d = bus.load_val;
         state_d = RUN;
         os_d    = bus.one_shot;
      end else if (bus.load) begin
         count_d = bus.load_val;
      end else if (state_q == RUN && bus.en) begin
         if (!os_q && count_q == bus.limit) begin
            count_d = bus.load_val;
         end else begin
            count_d = sum;
            wrap_d  = bus.up ? cout : ~cout;
            tc_d    = (sum == bus.limit);
            if (os_q && sum == bus.limit) state_d = DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= RESET_VAL;
         os_q    <= 1'b0;
         tc_q    <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         os_q    <= os_d;
         tc_q    <= tc_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.count   = count_q;
   assign bus.running = (state_q == RUN);
   assign bus.done    = (state_q == DONE);
   assign bus.tc      = tc_q;
   assign bus.wrap    = wrap_q;
endmodule
